// File: rtl/ov_fifo_reader_if.sv
// Pixel stream from the camera FIFO reader to display/processing logic.
// Valid/ready handshake; frame_done marks the end of a frame.
interface ov_fifo_reader_if;
    logic        pix_valid;
    logic        pix_ready;
    logic [15:0] pix_data;
    logic [8:0]  pix_x;
    logic [7:0]  pix_y;
    logic        frame_done;

    modport master (
        output pix_valid,
        output pix_data,
        output pix_x,
        output pix_y,
        output frame_done,
        input  pix_ready
    );

    modport slave (
        input  pix_valid,
        input  pix_data,
        input  pix_x,
        input  pix_y,
        input  frame_done,
        output pix_ready
    );
endinterface

// File: rtl/ov_fifo_reader.sv
// Camera frame FIFO read controller: handshake, read-reset, then two bytes per pixel
// at 4*RCLK_HALF+1 cycles/pixel; pix_ready low freezes fifo_rclk and holds the pixel.
module ov_fifo_reader #(
    parameter int H_PIXELS    = 320,
    parameter int V_LINES     = 240,
    parameter int RCLK_HALF   = 1,
    parameter int RRST_PULSES = 2
) (
    input  logic                    clk_24MHz,
    input  logic                    rst,
    input  logic                    initialized,
    input  logic                    new_frame,
    output logic                    frame_read,
    output logic                    fifo_rrst_n,
    output logic                    fifo_oe_n,
    output logic                    fifo_rclk,
    input  logic [7:0]              fifo_data,
    ov_fifo_reader_if.master        pix
);

    localparam int PH_W = (RCLK_HALF > 1) ? $clog2(RCLK_HALF) : 1;
    localparam int PC_W = (RRST_PULSES > 1) ? $clog2(RRST_PULSES) : 1;

    typedef enum logic [2:0] {
        IDLE,
        RRST,
        READ_HI,
        READ_LO,
        PRESENT,
        DONE,
        WAIT_CLR
    } state_t;

    state_t          state, state_n;
    logic [PH_W-1:0] phase_cnt, phase_cnt_n;
    logic [PC_W-1:0] pulse_cnt, pulse_cnt_n;
    logic            byte_sel, byte_sel_n;
    logic [7:0]      hi_byte, hi_byte_n;
    logic [7:0]      lo_byte, lo_byte_n;
    logic            frame_read_n, fifo_rrst_n_n, fifo_oe_n_n, fifo_rclk_n;
    logic            pix_valid_n, frame_done_n;
    logic [15:0]     pix_data_n;
    logic [8:0]      pix_x_n;
    logic [7:0]      pix_y_n;
    logic            last_half, last_x, last_y;

    assign last_half = (phase_cnt == PH_W'(RCLK_HALF - 1));
    assign last_x    = (pix.pix_x == 9'(H_PIXELS - 1));
    assign last_y    = (pix.pix_y == 8'(V_LINES - 1));

    always_comb begin
        state_n       = state;
        phase_cnt_n   = phase_cnt;
        pulse_cnt_n   = pulse_cnt;
        byte_sel_n    = byte_sel;
        hi_byte_n     = hi_byte;
        lo_byte_n     = lo_byte;
        frame_read_n  = frame_read;
        fifo_rrst_n_n = fifo_rrst_n;
        fifo_oe_n_n   = fifo_oe_n;
        fifo_rclk_n   = fifo_rclk;
        pix_valid_n   = pix.pix_valid;
        pix_data_n    = pix.pix_data;
        pix_x_n       = pix.pix_x;
        pix_y_n       = pix.pix_y;
        frame_done_n  = 1'b0;

        case (state)
            IDLE: begin
                if (initialized && new_frame) begin
                    frame_read_n  = 1'b0;
                    fifo_oe_n_n   = 1'b0;
                    fifo_rrst_n_n = 1'b0;
                    fifo_rclk_n   = 1'b1;
                    phase_cnt_n   = '0;
                    pulse_cnt_n   = '0;
                    state_n       = RRST;
                end
            end
            // fifo_rclk itself tells which half of the reset pulse we are in
            RRST: begin
                phase_cnt_n = phase_cnt + PH_W'(1);
                if (last_half) begin
                    phase_cnt_n = '0;
                    if (fifo_rclk) begin
                        fifo_rclk_n = 1'b0;
                    end else if (pulse_cnt == PC_W'(RRST_PULSES - 1)) begin
                        fifo_rrst_n_n = 1'b1;
                        fifo_rclk_n   = 1'b1;
                        state_n       = READ_HI;
                    end else begin
                        pulse_cnt_n = pulse_cnt + PC_W'(1);
                        fifo_rclk_n = 1'b1;
                    end
                end
            end
            READ_HI: begin
                phase_cnt_n = phase_cnt + PH_W'(1);
                if (last_half) begin
                    phase_cnt_n = '0;
                    if (!byte_sel) hi_byte_n = fifo_data;
                    else           lo_byte_n = fifo_data;
                    fifo_rclk_n = 1'b0;
                    state_n     = READ_LO;
                end
            end
            READ_LO: begin
                phase_cnt_n = phase_cnt + PH_W'(1);
                if (last_half) begin
                    phase_cnt_n = '0;
                    if (!byte_sel) begin
                        byte_sel_n  = 1'b1;
                        fifo_rclk_n = 1'b1;
                        state_n     = READ_HI;
                    end else begin
                        byte_sel_n  = 1'b0;
                        pix_data_n  = {hi_byte, lo_byte};
                        pix_valid_n = 1'b1;
                        state_n     = PRESENT;
                    end
                end
            end
            PRESENT: begin
                if (pix.pix_valid && pix.pix_ready) begin
                    pix_valid_n = 1'b0;
                    if (last_x) begin
                        pix_x_n = '0;
                        pix_y_n = last_y ? 8'd0 : pix.pix_y + 8'd1;
                    end else begin
                        pix_x_n = pix.pix_x + 9'd1;
                    end
                    if (last_x && last_y) begin
                        state_n = DONE;
                    end else begin
                        fifo_rclk_n = 1'b1;
                        state_n     = READ_HI;
                    end
                end
            end
            DONE: begin
                fifo_oe_n_n  = 1'b1;
                frame_read_n = 1'b1;
                frame_done_n = 1'b1;
                pix_x_n      = '0;
                pix_y_n      = '0;
                state_n      = WAIT_CLR;
            end
            // the writer may still be holding new_frame from the frame just read
            WAIT_CLR: begin
                if (!new_frame) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk_24MHz) begin
        if (rst) begin
            state          <= IDLE;
            phase_cnt      <= '0;
            pulse_cnt      <= '0;
            byte_sel       <= 1'b0;
            hi_byte        <= '0;
            lo_byte        <= '0;
            frame_read     <= 1'b1;
            fifo_rrst_n    <= 1'b1;
            fifo_oe_n      <= 1'b1;
            fifo_rclk      <= 1'b0;
            pix.pix_valid  <= 1'b0;
            pix.pix_data   <= '0;
            pix.pix_x      <= '0;
            pix.pix_y      <= '0;
            pix.frame_done <= 1'b0;
        end else begin
            state          <= state_n;
            phase_cnt      <= phase_cnt_n;
            pulse_cnt      <= pulse_cnt_n;
            byte_sel       <= byte_sel_n;
            hi_byte        <= hi_byte_n;
            lo_byte        <= lo_byte_n;
            frame_read     <= frame_read_n;
            fifo_rrst_n    <= fifo_rrst_n_n;
            fifo_oe_n      <= fifo_oe_n_n;
            fifo_rclk      <= fifo_rclk_n;
            pix.pix_valid  <= pix_valid_n;
            pix.pix_data   <= pix_data_n;
            pix.pix_x      <= pix_x_n;
            pix.pix_y      <= pix_y_n;
            pix.frame_done <= frame_done_n;
        end
    end

endmodule

// File: tb/tb_ov_fifo_reader.sv
// Bench for ov_fifo_reader: small 4x2 frames against a byte-stream FIFO model,
// plus a second instance with a divided read clock.
module tb_ov_fifo_reader;
    localparam int H = 4;
    localparam int V = 2;

    logic clk_24MHz = 1'b0;
    always #5 clk_24MHz = ~clk_24MHz;

    logic       rst, initialized, new_frame, new_frame3;
    logic       frame_read, fifo_rrst_n, fifo_oe_n, fifo_rclk;
    logic       frame_read3, fifo_rrst_n3, fifo_oe_n3, fifo_rclk3;
    logic [7:0] fifo_data  = 8'h00;
    logic [7:0] fifo_data3 = 8'h00;

    ov_fifo_reader_if pif ();
    ov_fifo_reader_if pif3 ();

    ov_fifo_reader #(.H_PIXELS(H), .V_LINES(V), .RCLK_HALF(1), .RRST_PULSES(2)) dut (
        .clk_24MHz(clk_24MHz), .rst(rst), .initialized(initialized), .new_frame(new_frame),
        .frame_read(frame_read), .fifo_rrst_n(fifo_rrst_n), .fifo_oe_n(fifo_oe_n),
        .fifo_rclk(fifo_rclk), .fifo_data(fifo_data), .pix(pif));

    ov_fifo_reader #(.H_PIXELS(H), .V_LINES(V), .RCLK_HALF(3), .RRST_PULSES(2)) dut3 (
        .clk_24MHz(clk_24MHz), .rst(rst), .initialized(initialized), .new_frame(new_frame3),
        .frame_read(frame_read3), .fifo_rrst_n(fifo_rrst_n3), .fifo_oe_n(fifo_oe_n3),
        .fifo_rclk(fifo_rclk3), .fifo_data(fifo_data3), .pix(pif3));

    typedef struct packed {
        logic [15:0] d;
        logic [8:0]  x;
        logic [7:0]  y;
    } pix_t;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    pix_t exp_q[$];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk_24MHz) cyc++;

    // FIFO model: each rising read clock emits the next byte of base, base+1, ...
    int   fifo_base = 0;
    int   rptr = 0, rptr3 = 0;
    int   rclk_toggles = 0, rrst_pulses = 0;
    logic prev_rclk = 1'b0, prev_rclk3 = 1'b0;

    always @(negedge clk_24MHz) begin
        if (fifo_rclk && !prev_rclk) begin
            if (!fifo_rrst_n) begin
                rptr = 0;
                rrst_pulses++;
            end else begin
                fifo_data = 8'(fifo_base + rptr);
                rptr++;
            end
        end
        if (fifo_rclk !== prev_rclk) rclk_toggles++;
        prev_rclk = fifo_rclk;
    end

    always @(negedge clk_24MHz) begin
        if (fifo_rclk3 && !prev_rclk3) begin
            if (!fifo_rrst_n3) rptr3 = 0;
            else begin
                fifo_data3 = 8'(rptr3);
                rptr3++;
            end
        end
        prev_rclk3 = fifo_rclk3;
    end

    // Downstream ready: 0 = always ready, 1 = random, 2 = manual
    int   ready_mode   = 0;
    logic manual_ready = 1'b1;
    initial begin
        pif.pix_ready  = 1'b1;
        pif3.pix_ready = 1'b1;
        forever begin
            @(posedge clk_24MHz);
            #2;
            case (ready_mode)
                0:       pif.pix_ready = 1'b1;
                1:       pif.pix_ready = ($urandom_range(0, 3) != 0);
                default: pif.pix_ready = manual_ready;
            endcase
        end
    end

    // Scoreboard monitor for the main instance
    pix_t e;
    int   done_cnt = 0, frame_starts = 0;
    logic prev_done = 1'b0, prev_fr = 1'b1;
    always @(negedge clk_24MHz) begin
        if (rst) begin
            exp_q.delete();
        end else begin
            if (pif.pix_valid && pif.pix_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_pixel", int'(pif.pix_data), -1);
                end else begin
                    e = exp_q.pop_front();
                    check("pix_data", int'(pif.pix_data), int'(e.d));
                    check("pix_x", int'(pif.pix_x), int'(e.x));
                    check("pix_y", int'(pif.pix_y), int'(e.y));
                end
            end
            if (pif.frame_done) begin
                done_cnt++;
                check("done_single_cycle", int'(prev_done), 0);
                check("queue_empty_at_done", exp_q.size(), 0);
                check("frame_read_at_done", int'(frame_read), 1);
                check("oe_n_at_done", int'(fifo_oe_n), 1);
            end
            if (prev_fr && !frame_read) frame_starts++;
        end
        prev_done = pif.frame_done;
        prev_fr   = frame_read;
    end

    // Monitor for the divided-clock instance: pixel spacing, high-phase length, data
    int   idx3 = 0, last_rise3 = -1, hi_run3 = 0;
    logic prev_vld3 = 1'b0;
    always @(negedge clk_24MHz) begin
        if (pif3.pix_valid && !prev_vld3) begin
            if (last_rise3 >= 0) check("pix_spacing_r3", cyc - last_rise3, 13);
            last_rise3 = cyc;
        end
        if (pif3.pix_valid && pif3.pix_ready) begin
            check("pix_data_r3", int'(pif3.pix_data),
                  ((2 * (idx3 % (H * V))) << 8) | (2 * (idx3 % (H * V)) + 1));
            idx3++;
        end
        if (pif3.frame_done) last_rise3 = -1;
        if (fifo_rclk3) hi_run3++;
        else begin
            if (hi_run3 != 0) check("rclk_high_r3", hi_run3, 3);
            hi_run3 = 0;
        end
        prev_vld3 = pif3.pix_valid;
    end

    task automatic drive_edge();
        @(posedge clk_24MHz);
        #1;
    endtask

    task automatic push_frame(input int base);
        pix_t p;
        for (int i = 0; i < H * V; i++) begin
            p.d = {8'(base + 2 * i), 8'(base + 2 * i + 1)};
            p.x = 9'(i % H);
            p.y = 8'(i / H);
            exp_q.push_back(p);
        end
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (!pif.frame_done && n < 3000) begin
            @(negedge clk_24MHz);
            n++;
        end
        check(name, int'(pif.frame_done), 1);
    endtask

    int t0, s0, d0, n;
    int b;

    initial begin
        rst = 1'b1; initialized = 1'b0; new_frame = 1'b0; new_frame3 = 1'b0;
        repeat (3) drive_edge();
        rst = 1'b0;
        @(negedge clk_24MHz);
        check("rst_frame_read", int'(frame_read), 1);
        check("rst_rrst_n", int'(fifo_rrst_n), 1);
        check("rst_oe_n", int'(fifo_oe_n), 1);
        check("rst_rclk", int'(fifo_rclk), 0);
        check("rst_pix_valid", int'(pif.pix_valid), 0);
        check("rst_pix_data", int'(pif.pix_data), 0);
        check("rst_pix_x", int'(pif.pix_x), 0);
        check("rst_pix_y", int'(pif.pix_y), 0);
        check("rst_frame_done", int'(pif.frame_done), 0);

        // new_frame without initialized must be ignored
        drive_edge();
        t0 = rclk_toggles;
        new_frame = 1'b1;
        repeat (50) drive_edge();
        @(negedge clk_24MHz);
        check("noinit_frame_read", int'(frame_read), 1);
        check("noinit_oe_n", int'(fifo_oe_n), 1);
        check("noinit_rclk_toggles", rclk_toggles - t0, 0);
        drive_edge();
        new_frame = 1'b0;
        repeat (2) drive_edge();
        initialized = 1'b1;
        repeat (2) drive_edge();

        // Basic frame with bytes 0x00, 0x01, ...
        fifo_base = 0;
        push_frame(0);
        s0 = rrst_pulses;
        new_frame = 1'b1;
        @(negedge clk_24MHz);
        check("frame_read_before_edge", int'(frame_read), 1);
        @(negedge clk_24MHz);
        check("frame_read_fall", int'(frame_read), 0);
        check("oe_n_fall", int'(fifo_oe_n), 0);
        check("rrst_n_low", int'(fifo_rrst_n), 0);
        wait_done("basic_done");
        check("basic_rrst_pulses", rrst_pulses - s0, 2);

        // new_frame still high after frame_done: no restart
        t0 = rclk_toggles;
        repeat (3) begin
            @(negedge clk_24MHz);
            check("stale_frame_read", int'(frame_read), 1);
        end
        check("stale_rclk_toggles", rclk_toggles - t0, 0);
        drive_edge();
        new_frame = 1'b0;
        repeat (2) drive_edge();

        // Backpressure at pixel (2,0)
        push_frame(0);
        s0 = frame_starts;
        ready_mode = 2;
        manual_ready = 1'b1;
        new_frame = 1'b1;
        n = 0;
        while (!(pif.pix_valid && pif.pix_x == 9'd1 && pif.pix_y == 8'd0) && n < 300) begin
            @(negedge clk_24MHz);
            n++;
        end
        check("reach_pixel_1_0", int'(pif.pix_x), 1);
        drive_edge();
        manual_ready = 1'b0;
        n = 0;
        @(negedge clk_24MHz);
        while (!pif.pix_valid && n < 100) begin
            @(negedge clk_24MHz);
            n++;
        end
        t0 = rclk_toggles;
        repeat (10) begin
            @(negedge clk_24MHz);
            check("stall_valid", int'(pif.pix_valid), 1);
            check("stall_data", int'(pif.pix_data), 16'h0405);
        end
        check("stall_x", int'(pif.pix_x), 2);
        check("stall_rclk_toggles", rclk_toggles - t0, 0);
        drive_edge();
        manual_ready = 1'b1;
        wait_done("bp_done");
        drive_edge();
        new_frame = 1'b0;
        check("one_restart", frame_starts - s0, 1);
        ready_mode = 0;
        repeat (2) drive_edge();

        // Reset in the middle of the frame, around pixel (1,1)
        fifo_base = 8'h40;
        push_frame(8'h40);
        d0 = done_cnt;
        new_frame = 1'b1;
        n = 0;
        while (!(pif.pix_x == 9'd1 && pif.pix_y == 8'd1) && n < 300) begin
            @(negedge clk_24MHz);
            n++;
        end
        check("reach_pixel_1_1", int'(pif.pix_y), 1);
        drive_edge();
        rst = 1'b1;
        new_frame = 1'b0;
        @(posedge clk_24MHz);
        @(negedge clk_24MHz);
        check("midrst_frame_read", int'(frame_read), 1);
        check("midrst_oe_n", int'(fifo_oe_n), 1);
        check("midrst_rrst_n", int'(fifo_rrst_n), 1);
        check("midrst_pix_valid", int'(pif.pix_valid), 0);
        check("midrst_rclk", int'(fifo_rclk), 0);
        check("midrst_pix_x", int'(pif.pix_x), 0);
        check("midrst_pix_y", int'(pif.pix_y), 0);
        drive_edge();
        rst = 1'b0;
        repeat (20) drive_edge();
        check("midrst_no_done", done_cnt - d0, 0);

        // Fresh frames with random data and random backpressure
        for (int f = 0; f < 4; f++) begin
            b = int'($urandom_range(0, 255));
            fifo_base = b;
            push_frame(b);
            s0 = rrst_pulses;
            ready_mode = (f == 0) ? 0 : 1;
            new_frame = 1'b1;
            wait_done("rand_done");
            check("rand_rrst_pulses", rrst_pulses - s0, 2);
            drive_edge();
            new_frame = 1'b0;
            repeat (int'($urandom_range(1, 5))) drive_edge();
        end
        ready_mode = 0;
        check("total_frames", done_cnt, 6);
        check("queue_drained", exp_q.size(), 0);

        // Divided read clock instance
        drive_edge();
        new_frame3 = 1'b1;
        n = 0;
        while (!pif3.frame_done && n < 3000) begin
            @(negedge clk_24MHz);
            n++;
        end
        check("r3_done", int'(pif3.frame_done), 1);
        check("r3_pixels", idx3, H * V);
        check("r3_frame_read", int'(frame_read3), 1);
        drive_edge();
        new_frame3 = 1'b0;
        repeat (3) drive_edge();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ov_fifo_reader.md
Name: ov_fifo_reader

Overview:
- Read-side controller for the camera frame FIFO.
- The write-side controller raises new_frame once a full frame is stored. This block then does the following:
  - performs the frame_read handshake;
  - read-resets the FIFO;
  - clocks out H_PIXELS x V_LINES two-byte pixels;
  - presents each pixel, with its coordinates, on a valid/ready stream to the downstream display/processing logic.
- The FIFO read clock is generated in fabric from clk_24MHz. Downstream backpressure stalls that read clock.

Parameters:
- H_PIXELS, 320, pixels per line.
- V_LINES, 240, lines per frame.
- RCLK_HALF, 1, clk_24MHz cycles per fifo_rclk half-period (>=1).
- RRST_PULSES, 2, fifo_rclk pulses issued while fifo_rrst_n is low.

Ports:
- clk_24MHz  in  1  system clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- initialized  in  1  camera configured; block stays in IDLE while low.
- new_frame  in  1  frame available, from the write-side controller.
- frame_read  out  1  high = reader idle; low = frame read in progress.
- fifo_rrst_n  out  1  FIFO read-pointer reset, active low.
- fifo_oe_n  out  1  FIFO output enable, active low.
- fifo_rclk  out  1  FIFO read clock.
- fifo_data  in  8  FIFO read data.
- pix_valid  out  1  pix_data/pix_x/pix_y valid.
- pix_ready  in  1  downstream accepts the pixel when pix_valid && pix_ready.
- pix_data  out  16  {first byte, second byte} of the pixel.
- pix_x  out  9  column, 0..H_PIXELS-1.
- pix_y  out  8  line, 0..V_LINES-1.
- frame_done  out  1  one-cycle pulse after the last pixel is accepted.

Behaviour:
- Reset values (also applied on reset mid-operation):
  - frame_read=1, fifo_rrst_n=1, fifo_oe_n=1, fifo_rclk=0;
  - pix_valid=0, pix_data=0, pix_x=0, pix_y=0, frame_done=0;
  - state=IDLE, all counters 0.
- Reset mid-frame abandons the frame with no frame_done. The next new_frame starts from RRST.
- IDLE:
  - Leave only when initialized && new_frame.
  - On leaving: frame_read<=0 and fifo_oe_n<=0 in the same edge; go to RRST.
- RRST:
  - fifo_rrst_n=0.
  - Generate RRST_PULSES full fifo_rclk periods (RCLK_HALF cycles high, then RCLK_HALF cycles low).
  - Then fifo_rrst_n<=1 and go to READ_HI. No data is captured in this state.
- READ_HI:
  - fifo_rclk=1 for RCLK_HALF cycles.
  - On the last cycle of the high phase, capture fifo_data: into the high byte if byte_sel=0, into the low byte if byte_sel=1. Then go to READ_LO.
- READ_LO:
  - fifo_rclk=0 for RCLK_HALF cycles.
  - At the end of the phase, if byte_sel was 0: toggle byte_sel and go to READ_HI.
  - Otherwise: load pix_data, set pix_valid=1, byte_sel=0, go to PRESENT.
- PRESENT:
  - Outputs are held stable and fifo_rclk stays 0 until the pixel is accepted (pix_valid && pix_ready).
  - On acceptance: pix_valid<=0, then advance the coordinates:
    - if pix_x==H_PIXELS-1: pix_x<=0 and pix_y increments;
    - otherwise pix_x increments.
  - If the accepted pixel was (H_PIXELS-1, V_LINES-1): go to DONE. Otherwise go to READ_HI.
  - Unstalled throughput: one pixel per 4*RCLK_HALF+1 cycles.
- DONE (one cycle):
  - fifo_oe_n<=1, frame_read<=1, frame_done<=1 (pulse), pix_x<=0, pix_y<=0.
  - Go to WAIT_CLR.
- WAIT_CLR:
  - Stay until new_frame==0, then go to IDLE.
  - This prevents restarting on the stale new_frame the writer has not yet cleared.
- initialized dropping mid-frame has no effect. It is sampled only in IDLE.
- Coordinate counters never exceed their limits. The wrap occurs only on acceptance.
- fifo_rclk is a registered output: glitch-free, and its edges are aligned to clk_24MHz.

Test Plan:
- Basic frame, H_PIXELS=4, V_LINES=2, RCLK_HALF=1, pix_ready=1, FIFO model returns byte sequence 0x00,0x01,...:
  - frame_read falls the cycle after new_frame=1;
  - exactly 2 fifo_rclk pulses occur with fifo_rrst_n=0;
  - 8 pixels 0x0001,0x0203,...,0x0E0F are produced, with (x,y) going (0,0)..(3,0),(0,1)..(3,1);
  - frame_done pulses once, then frame_read=1.
- Backpressure: pix_ready=0 for 10 cycles at pixel (2,0):
  - pix_valid stays 1 and pix_data stays 0x0405;
  - no fifo_rclk edges during the stall;
  - the stream resumes with 0x0607 after pix_ready=1.
- Stale new_frame: hold new_frame=1 for 3 cycles after frame_done → block stays in WAIT_CLR and frame_read stays 1. When new_frame drops and rises again, exactly one new frame read starts.
- Not initialized: new_frame=1 with initialized=0 for 50 cycles → frame_read=1, fifo_oe_n=1, and fifo_rclk toggles 0 times.
- Reset mid-frame: assert rst at pixel (1,1) →
  - next cycle: frame_read=1, fifo_oe_n=1, fifo_rrst_n=1, pix_valid=0, fifo_rclk=0;
  - no frame_done;
  - the next frame starts at (0,0) with a fresh RRST sequence.
- Divided read clock, RCLK_HALF=3: with no stall, consecutive pix_valid rising edges are 13 cycles apart, and each fifo_rclk phase lasts 3 cycles.
